// File: rtl/parallel_cnt_sched_pkg.sv
// rtl/parallel_cnt_sched_pkg.sv - shared state encoding and width defaults for parallel_cnt_sched
package parallel_cnt_sched_pkg;

   localparam int WIN_W_DEF = 8;
   localparam int SUM_W_DEF = WIN_W_DEF + 3;
   localparam int PCNT_W    = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/parallelCnt7.sv
// rtl/parallelCnt7.sv - 7-input parallel counter (population count of 7 bits) built from full adders
module parallelCnt7 (
   input  logic [6:0] in,
   output logic [2:0] out
);

   logic w_s1, w_c1, w_s2, w_c2, w_c3;

   // Two first-level full adders reduce six inputs; the third folds in in[6].
   assign w_s1   = in[0] ^ in[1] ^ in[2];
   assign w_c1   = (in[0] & in[1]) | (in[2] & (in[0] ^ in[1]));
   assign w_s2   = in[3] ^ in[4] ^ in[5];
   assign w_c2   = (in[3] & in[4]) | (in[5] & (in[3] ^ in[4]));
   assign out[0] = w_s1 ^ w_s2 ^ in[6];
   assign w_c3   = (w_s1 & w_s2) | (in[6] & (w_s1 ^ w_s2));
   assign out[1] = w_c1 ^ w_c2 ^ w_c3;
   assign out[2] = (w_c1 & w_c2) | (w_c3 & (w_c1 ^ w_c2));

endmodule

// File: rtl/parallel_cnt_sched.sv
// rtl/parallel_cnt_sched.sv - windowed popcount accumulator; PARALLEL_CNT_SCHED_PIPE_EN registers the popcount and adds a DRAIN cycle
module parallel_cnt_sched
   import parallel_cnt_sched_pkg::*;
#(
   parameter int WIN_W = WIN_W_DEF,
   parameter int SUM_W = WIN_W + 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             clear,
   input  logic [WIN_W-1:0] win_len,
   input  logic             in_valid,
   input  logic [6:0]       in_bits,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   output logic [SUM_W-1:0] sum
);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIN_W-1:0]   r_win_len;
   logic [WIN_W-1:0]   r_cnt;
   logic [WIN_W-1:0]   w_cnt_inc;
   logic [SUM_W-1:0]   r_sum;
   logic [PCNT_W-1:0]  w_pcnt;
   logic               w_accept;
   logic               w_last;

   parallelCnt7 u_pcnt (
      .in  (in_bits),
      .out (w_pcnt)
   );

   assign w_accept  = (r_state == RUN) && in_valid;
   assign w_cnt_inc = r_cnt + 1'b1;
   assign w_last    = w_accept && (w_cnt_inc == r_win_len);

   assign in_ready = (r_state == RUN);
   assign busy     = (r_state != IDLE);
   assign done     = (r_state == DONE);
   assign sum      = r_sum;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = (win_len == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (w_last) begin
`ifdef PARALLEL_CNT_SCHED_PIPE_EN
               w_state_nxt = DRAIN;
`else
               w_state_nxt = DONE;
`endif
            end
         end
         DRAIN:   w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      if (clear) begin
         w_state_nxt = IDLE;
      end
   end

`ifdef PARALLEL_CNT_SCHED_PIPE_EN
   logic [PCNT_W-1:0] r_pcnt;

   // r_pcnt is zero on any cycle without an accepted beat, so RUN/DRAIN can add it unconditionally.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_sum     <= '0;
         r_cnt     <= '0;
         r_win_len <= '0;
         r_pcnt    <= '0;
      end else begin
         r_pcnt <= w_accept ? w_pcnt : '0;
         if (r_state == IDLE && start) begin
            r_win_len <= win_len;
            r_sum     <= '0;
            r_cnt     <= '0;
         end else if (r_state == RUN || r_state == DRAIN) begin
            r_sum <= r_sum + {{(SUM_W-PCNT_W){1'b0}}, r_pcnt};
         end
         if (w_accept) begin
            r_cnt <= w_cnt_inc;
         end
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_sum     <= '0;
         r_cnt     <= '0;
         r_win_len <= '0;
      end else begin
         if (r_state == IDLE && start) begin
            r_win_len <= win_len;
            r_sum     <= '0;
            r_cnt     <= '0;
         end else if (w_accept) begin
            r_sum <= r_sum + {{(SUM_W-PCNT_W){1'b0}}, w_pcnt};
            r_cnt <= w_cnt_inc;
         end
      end
   end
`endif

endmodule

// File: tb/tb_parallel_cnt_sched.sv
// tb/tb_parallel_cnt_sched.sv - self-checking bench for parallel_cnt_sched against a popcount-sum model
module tb_parallel_cnt_sched;

`ifdef PARALLEL_CNT_SCHED_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk;
   logic        rst;
   logic        start;
   logic        clear;
   logic [7:0]  win_len;
   logic        in_valid;
   logic [6:0]  in_bits;
   logic        in_ready;
   logic        busy;
   logic        done;
   logic [10:0] sum;

   int n_chk;
   int n_fail;

   logic [6:0] bq[$];
   bit         vq[$];
   bit         poke_start;

   parallel_cnt_sched dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .clear    (clear),
      .win_len  (win_len),
      .in_valid (in_valid),
      .in_bits  (in_bits),
      .in_ready (in_ready),
      .busy     (busy),
      .done     (done),
      .sum      (sum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_zero(input string name);
      n_chk++;
      if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || sum !== 11'd0) begin
         n_fail++;
         $display("FAIL %s: busy=%b done=%b in_ready=%b sum=%0d, required all zero", name, busy, done, in_ready, sum);
      end
   endtask

   // Drives one window using bq (beats) and vq (valid pattern), then checks sum, latency and handshake.
   task automatic run_window(input int len, input string name);
      int exp_sum, acc, cyc, done_cnt, done_at;
      bit v;
      exp_sum = 0;
      acc = 0;
      cyc = 0;
      done_cnt = 0;
      done_at = 0;
      start = 1'b1;
      win_len = len[7:0];
      step();
      start = 1'b0;
      while (acc < len && cyc < 5000) begin
         v = (vq.size() > 0) ? vq.pop_front() : 1'b1;
         in_valid = v;
         in_bits = v ? bq[acc] : 7'($urandom);
         if (poke_start) begin
            start = $urandom_range(0, 1) != 0;
            win_len = 8'($urandom);
         end
         n_chk++;
         if (in_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_run: in_ready=%b done=%b busy=%b at cycle %0d, required 1/0/1", name, in_ready, done, busy, cyc);
         end
         if (v) begin
            exp_sum += $countones(bq[acc]);
            acc++;
         end
         step();
         cyc++;
      end
      in_valid = 1'b0;
      start = 1'b0;
      n_chk++;
      if (cyc >= 5000) begin
         n_fail++;
         $display("FAIL %s_timeout: accepted %0d of %0d beats", name, acc, len);
      end
      for (int k = 1; k <= 3; k++) begin
         if (done === 1'b1) begin
            done_cnt++;
            done_at = k;
         end
         n_chk++;
         if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_ready_drop: in_ready=%b %0d cycles after final beat, required 0", name, in_ready, k);
         end
         step();
      end
      n_chk++;
      if (done_cnt != 1 || done_at != LAT) begin
         n_fail++;
         $display("FAIL %s_done: pulses=%0d at=%0d, required 1 at %0d", name, done_cnt, done_at, LAT);
      end
      n_chk++;
      if (sum !== 11'(exp_sum) || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_sum: sum=%0d busy=%b, required %0d busy=0", name, sum, busy, exp_sum);
      end
      bq.delete();
      vq.delete();
      poke_start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b1;
      clear = 1'b1;
      in_valid = 1'b1;
      win_len = 8'd5;
      step();
      step();
      check_idle_zero("reset");
      rst = 1'b0;
      start = 1'b0;
      clear = 1'b0;
      in_valid = 1'b0;
      step();
      check_idle_zero("reset_release");
   endtask

   task automatic test_back_to_back();
      bq = '{7'h01, 7'h03, 7'h7F, 7'h41};
      run_window(4, "back_to_back");
   endtask

   task automatic test_bubbles();
      bq = '{7'h7F, 7'h7F, 7'h7F};
      vq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      run_window(3, "bubbles");
   endtask

   task automatic test_zero_len();
      int seen_ready;
      seen_ready = 0;
      start = 1'b1;
      win_len = 8'd0;
      step();
      start = 1'b0;
      n_chk++;
      if (done !== 1'b1 || sum !== 11'd0) begin
         n_fail++;
         $display("FAIL zero_len_done: done=%b sum=%0d, required 1 and 0", done, sum);
      end
      if (in_ready === 1'b1) seen_ready++;
      step();
      if (in_ready === 1'b1) seen_ready++;
      n_chk++;
      if (seen_ready != 0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_len_ready: in_ready seen %0d times done=%b, required 0 and 0", seen_ready, done);
      end
   endtask

   task automatic test_max_len();
      for (int i = 0; i < 255; i++) bq.push_back(7'h7F);
      run_window(255, "max_len");
      n_chk++;
      if (sum !== 11'd1785) begin
         n_fail++;
         $display("FAIL max_len_value: sum=%0d, required 1785", sum);
      end
   endtask

   task automatic test_clear();
      int done_seen;
      done_seen = 0;
      start = 1'b1;
      win_len = 8'd5;
      step();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_bits = 7'h7F;
         step();
      end
      clear = 1'b1;
      start = 1'b1;
      in_bits = 7'h7F;
      step();
      clear = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      check_idle_zero("clear");
      for (int i = 0; i < 4; i++) begin
         if (done === 1'b1 || busy === 1'b1) done_seen++;
         step();
      end
      n_chk++;
      if (done_seen != 0) begin
         n_fail++;
         $display("FAIL clear_no_done: busy/done seen %0d cycles after clear, required 0", done_seen);
      end
      bq = '{7'h15, 7'h2A, 7'h00};
      run_window(3, "after_clear");
   endtask

   task automatic test_rst_mid_run();
      start = 1'b1;
      win_len = 8'd6;
      step();
      start = 1'b0;
      in_valid = 1'b1;
      in_bits = 7'h33;
      step();
      step();
      rst = 1'b1;
      start = 1'b1;
      in_valid = 1'b1;
      step();
      check_idle_zero("rst_mid_run");
      rst = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      step();
      check_idle_zero("rst_mid_run_hold");
      bq = '{7'h7F, 7'h01, 7'h10, 7'h7E, 7'h03};
      poke_start = 1'b1;
      run_window(5, "start_in_run_ignored");
   endtask

   task automatic test_random();
      int len;
      for (int w = 0; w < 8; w++) begin
         len = $urandom_range(1, 24);
         for (int i = 0; i < len; i++) bq.push_back(7'($urandom));
         for (int i = 0; i < 3 * len; i++) vq.push_back($urandom_range(0, 9) < 7);
         poke_start = $urandom_range(0, 1) != 0;
         run_window(len, $sformatf("random%0d", w));
      end
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      poke_start = 1'b0;
      rst = 1'b1;
      start = 1'b0;
      clear = 1'b0;
      win_len = '0;
      in_valid = 1'b0;
      in_bits = '0;
      test_reset();
      test_back_to_back();
      test_bubbles();
      test_zero_len();
      test_max_len();
      test_clear();
      test_rst_mid_run();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
